dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder: the slave end of the CPU load/store request interface.
- Accepts one request at a time over a valid/ready request channel and services it from internal word-organised storage.
- Inserts a programmable number of wait states, then returns data/completion over a valid/ready response channel.
- Replaces the combinational memory stage once the core issues loads/stores through a handshaked port.

Parameters:
- ADDR_WIDTH, 10, word-address bits; storage depth = 2**ADDR_WIDTH 32-bit words.
- WAIT_CYCLES, 2, wait states inserted between request accept and memory access (0..15).

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request
- req_we  input  1  1 = store, 0 = load
- req_addr  input  32  byte address
- req_wdata  input  32  store data, lane-aligned (byte k on bits 8k+7:8k)
- req_be  input  4  byte enables, lane-aligned
- rsp_valid  output  1  response present
- rsp_ready  input  1  initiator accepts response
- rsp_rdata  output  32  load data (full word); 0 for stores
- rsp_err  output  1  request rejected (see Optional Feature)

Behaviour:
- Reset (sync, active-high):
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
  - Storage contents are NOT reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - Accept on req_valid&&req_ready; capture we/addr/wdata/be.
  - WAIT_CYCLES==0: perform the access on the accept edge, go to RESP.
  - Otherwise: load cnt=WAIT_CYCLES, go to WAIT.
- WAIT:
  - req_ready=0.
  - cnt==1: perform the access, go to RESP.
  - Otherwise: cnt decrements.
- Access:
  - Word index = captured addr[ADDR_WIDTH+1:2]; higher address bits are ignored, so addresses alias/wrap modulo depth.
  - Store: write only lanes with be[k]=1; rsp_rdata<=0.
  - Load: rsp_rdata<=full stored word, be ignored for data.
  - A store followed by a load to the same word returns the new data.
- RESP:
  - rsp_valid=1; rsp_rdata/rsp_err held stable while rsp_valid&&!rsp_ready.
  - On rsp_ready: rsp_valid<=0 and go to IDLE.
  - No new request is accepted in RESP.
- Latency: accept in cycle 0 → rsp_valid high in cycle WAIT_CYCLES+1.
- Throughput: minimum period between accepts is WAIT_CYCLES+2 cycles.
- req_valid is don't-care while req_ready=0; request inputs are only sampled at accept.
- Reset mid-transaction: pending access whose access edge has not occurred is dropped (no write); a response in RESP is discarded; FSM returns to IDLE.
- reset and req_valid in the same cycle: reset wins, request not accepted.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- Defined: at access time, check captured be against addr[1:0].
  - Legal patterns: byte = single lane k with k==addr[1:0]; half = 0011@00, 1100@10; word = 1111@00.
  - Anything else (including 0000) is illegal.
  - Illegal store: no write.
  - Illegal load: rsp_rdata=0.
  - Illegal request of either kind: rsp_err=1 with rsp_valid.
  - Latency and FSM are unchanged.
- Undefined: no check; rsp_err tied 0; every be pattern is written as given.

Test Plan:
- WAIT_CYCLES=2:
  - store addr 0x10, wdata 0xDEADBEEF, be 1111 accepted cycle 0 → rsp_valid in cycle 3, rsp_rdata=0.
  - Then load 0x10 → rsp_rdata=0xDEADBEEF.
- Byte store addr 0x11, wdata 0x0000AA00, be 0010 over word 0xDEADBEEF → load 0x10 returns 0xDEADAAEF.
- Backpressure: hold rsp_ready=0 for 5 cycles on a load → rsp_valid and rsp_rdata stable all 5 cycles, req_ready=0; release → IDLE next cycle, req_ready=1.
- Aliasing, ADDR_WIDTH=10: store 0x12345678 to 0x0 → load 0x1000 returns 0x12345678.
- Reset during WAIT of a store to 0x20 (prior value 0x11111111) → after reset, load 0x20 returns 0x11111111; rsp_valid=0 during and right after reset.
- DMEM_ALIGN_CHECK_EN:
  - store addr 0x21, be 0011 → rsp_err=1, word unchanged.
  - Load addr 0x22, be 1100 → rsp_err=0.
  - Without macro, same store writes lanes 0-1 and rsp_err=0.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, WAIT_CYCLES wait states, then a held response. Optional be/addr alignment check under DMEM_ALIGN_CHECK_EN.
// Latency: accept in cycle 0, rsp_valid in cycle WAIT_CYCLES+1; minimum accept-to-accept period is WAIT_CYCLES+2.
// Backpressure: req_ready is low outside IDLE; the response is held stable until rsp_ready.
module dmem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        acc_fire;

    logic                  cap_we;
    logic [ADDR_WIDTH+1:0] cap_addr;
    logic [31:0]           cap_wdata;
    logic [3:0]            cap_be;

    logic                  acc_we;
    logic [ADDR_WIDTH+1:0] acc_addr;
    logic [31:0]           acc_wdata;
    logic [3:0]            acc_be;
    logic [ADDR_WIDTH-1:0] acc_idx;
    logic                  acc_ok;

    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        acc_fire  = 1'b0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        acc_fire  = 1'b1;
                        state_nxt = ST_RESP;
                    end else begin
                        cnt_nxt   = 4'(WAIT_CYCLES);
                        state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == 4'd1) begin
                    acc_fire  = 1'b1;
                    state_nxt = ST_RESP;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (state == ST_IDLE && req_valid) begin
            cap_we    <= req_we;
            cap_addr  <= req_addr[ADDR_WIDTH+1:0];
            cap_wdata <= req_wdata;
            cap_be    <= req_be;
        end
    end

    // With zero wait states the access happens on the accept edge, so it must use the live request.
    always_comb begin
        if (state == ST_IDLE) begin
            acc_we    = req_we;
            acc_addr  = req_addr[ADDR_WIDTH+1:0];
            acc_wdata = req_wdata;
            acc_be    = req_be;
        end else begin
            acc_we    = cap_we;
            acc_addr  = cap_addr;
            acc_wdata = cap_wdata;
            acc_be    = cap_be;
        end
    end

    assign acc_idx = acc_addr[ADDR_WIDTH+1:2];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[31:ADDR_WIDTH+2], acc_addr[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
    always_comb begin
        case (acc_be)
            4'b0001: acc_ok = (acc_addr[1:0] == 2'd0);
            4'b0010: acc_ok = (acc_addr[1:0] == 2'd1);
            4'b0100: acc_ok = (acc_addr[1:0] == 2'd2);
            4'b1000: acc_ok = (acc_addr[1:0] == 2'd3);
            4'b0011: acc_ok = (acc_addr[1:0] == 2'd0);
            4'b1100: acc_ok = (acc_addr[1:0] == 2'd2);
            4'b1111: acc_ok = (acc_addr[1:0] == 2'd0);
            default: acc_ok = 1'b0;
        endcase
    end

    logic err_q;
    always_ff @(posedge clk) begin
        if (reset)         err_q <= 1'b0;
        else if (acc_fire) err_q <= ~acc_ok;
    end
    assign rsp_err = err_q;
`else
    assign acc_ok  = 1'b1;
    assign rsp_err = 1'b0;
`endif

    // Storage is deliberately not reset; a reset on the access edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!reset && acc_fire && acc_we && acc_ok) begin
            for (int k = 0; k < 4; k++) begin
                if (acc_be[k]) mem[acc_idx][8*k +: 8] <= acc_wdata[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= 32'd0;
        end else if (acc_fire) begin
            rdata_q <= (!acc_we && acc_ok) ? mem[acc_idx] : 32'd0;
        end
    end
    assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboarded bench for dmem_responder: expected responses are queued at issue and compared when rsp_valid appears.
module tb_dmem_responder;

    localparam int ADDR_WIDTH  = 10;
    localparam int WAIT_CYCLES = 2;
    localparam int DEPTH       = 1 << ADDR_WIDTH;

`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;

    logic [32:0] exp_q [$];
    logic [31:0] model [int];

    dmem_responder #(.ADDR_WIDTH(ADDR_WIDTH), .WAIT_CYCLES(WAIT_CYCLES)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit legal(input logic [1:0] a, input logic [3:0] be);
        case ({a, be})
            6'b00_0001, 6'b01_0010, 6'b10_0100, 6'b11_1000,
            6'b00_0011, 6'b10_1100, 6'b00_1111: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input int hold);
        int          idx;
        bit          ok;
        logic [31:0] word;
        logic [32:0] exp;
        int          lat;
        int          guard;
        idx  = int'((addr >> 2) & (DEPTH - 1));
        ok   = !CHK_EN || legal(addr[1:0], be);
        word = model.exists(idx) ? model[idx] : 32'd0;
        if (we) begin
            if (ok) begin
                for (int k = 0; k < 4; k++)
                    if (be[k]) word[8*k +: 8] = wdata[8*k +: 8];
                model[idx] = word;
            end
            exp = {!ok, 32'd0};
        end else begin
            exp = {!ok, ok ? word : 32'd0};
        end
        exp_q.push_back(exp);

        rsp_ready = (hold == 0);
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        req_valid = 1'b1;
        guard = 0;
        while (!req_ready && guard < 50) begin
            tick();
            guard++;
        end
        chk("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFFF;
        req_wdata = 32'hFFFF_FFFF;
        lat = 1;
        while (!rsp_valid && lat < 50) begin
            tick();
            lat++;
        end
        chk("rsp_valid_seen", {31'd0, rsp_valid}, 32'd1);
        chk("latency", lat, WAIT_CYCLES + 1);
        exp = exp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, exp[31:0]);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, exp[32]});
        for (int i = 0; i < hold; i++) begin
            chk("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("hold_rsp_rdata", rsp_rdata, exp[31:0]);
            chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        chk("post_rsp_req_ready", {31'd0, req_ready}, 32'd1);
        chk("post_rsp_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        req_be    = 4'd0;
        rsp_ready = 1'b1;
        repeat (3) tick();
        chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
        reset = 1'b0;
        tick();

        do_req(1'b1, 32'h10, 32'hDEAD_BEEF, 4'b1111, 0);
        do_req(1'b0, 32'h10, 32'h0, 4'b1111, 0);
        do_req(1'b1, 32'h11, 32'h0000_AA00, 4'b0010, 0);
        do_req(1'b0, 32'h10, 32'h0, 4'b1111, 0);
        chk("byte_merge_model", model[4], 32'hDEAD_AAEF);
        do_req(1'b0, 32'h10, 32'h0, 4'b1111, 5);

        do_req(1'b1, 32'h0, 32'h1234_5678, 4'b1111, 0);
        do_req(1'b0, 32'h1000, 32'h0, 4'b1111, 0);

        // Reset while a store sits in WAIT: the write must be dropped.
        do_req(1'b1, 32'h20, 32'h1111_1111, 4'b1111, 0);
        req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h5555_5555; req_be = 4'b1111;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("wait_req_ready", {31'd0, req_ready}, 32'd0);
        reset = 1'b1;
        tick();
        chk("mid_reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < WAIT_CYCLES + 2; i++) begin
            chk("post_reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            tick();
        end
        do_req(1'b0, 32'h20, 32'h0, 4'b1111, 0);

        // Reset and req_valid together: the request must not be taken.
        reset = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h24; req_be = 4'b1111;
        tick();
        reset = 1'b0; req_valid = 1'b0;
        chk("reset_wins_req_ready", {31'd0, req_ready}, 32'd1);
        for (int i = 0; i < WAIT_CYCLES + 2; i++) begin
            chk("reset_wins_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            tick();
        end

        do_req(1'b1, 32'h21, 32'hAAAA_BBBB, 4'b0011, 0);
        do_req(1'b0, 32'h20, 32'h0, 4'b1111, 0);
        do_req(1'b0, 32'h22, 32'h0, 4'b1100, 0);

        for (int i = 0; i < 8; i++)
            do_req(1'b1, 32'h40 + 32'(4 * i), $urandom, 4'b1111, 0);
        for (int i = 0; i < 24; i++) begin
            logic [31:0] a;
            a = 32'h40 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
            do_req(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                   $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
